timer_irq: RTL and testbench

TIMER_IRQ -- requirements
Module: timer_irq

---
 rtl/timer_irq.sv | 112 +++++++++++
 tb/tb_timer_irq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/timer_irq.sv
// Memory-mapped down-counting timer with auto-reload/one-shot modes and a level interrupt.
// Optional prescaler is built only when TIMER_PRESCALER_EN is defined.
module timer_irq #(
    parameter logic [15:0] BASE_ADDR = 16'h00F8,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        oe,
    input  logic [15:0] addresses,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_LOAD   = 3'd1;
    localparam logic [2:0] A_COUNT  = 3'd2;
    localparam logic [2:0] A_PRESC  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic             en, auto_rl, ie, pend;
    logic [CNT_W-1:0] load, count;
    logic             sel, tick;
    logic [2:0]       idx;
    logic             wr_ctrl, wr_load, wr_status, expire;

    assign sel       = (addresses[15:3] == BASE_ADDR[15:3]);
    assign idx       = addresses[2:0];
    assign wr_ctrl   = we && sel && (idx == A_CTRL);
    assign wr_load   = we && sel && (idx == A_LOAD);
    assign wr_status = we && sel && (idx == A_STATUS);
    assign expire    = tick && (count == '0);

`ifdef TIMER_PRESCALER_EN
    logic [CNT_W-1:0] prescale, pre;
    logic             wr_presc;

    assign wr_presc = we && sel && (idx == A_PRESC);
    assign tick     = en && (pre == prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            pre      <= '0;
        end else begin
            if (wr_presc)
                prescale <= wdata[CNT_W-1:0];
            // pre parks at 0 while disabled so a fresh enable starts a full prescale period
            if (!en || pre == prescale)
                pre <= '0;
            else
                pre <= pre + 1'b1;
        end
    end
`else
    assign tick = en;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            load    <= '0;
            count   <= '0;
            pend    <= 1'b0;
        end else begin
            // Bus writes override the tick-driven updates of EN and COUNT
            if (wr_ctrl)
                {ie, auto_rl, en} <= wdata[2:0];
            else if (expire && !auto_rl)
                en <= 1'b0;

            if (wr_load) begin
                load  <= wdata[CNT_W-1:0];
                count <= wdata[CNT_W-1:0];
            end else if (tick) begin
                if (count != '0)
                    count <= count - 1'b1;
                else if (auto_rl)
                    count <= load;
            end

            // A same-cycle expiry beats a software clear so no event is lost
            if (expire)
                pend <= 1'b1;
            else if (wr_status && wdata[0])
                pend <= 1'b0;
        end
    end

    assign irq = pend && ie;

    always_comb begin
        rdata = 16'h0000;
        if (oe && sel) begin
            case (idx)
                A_CTRL:   rdata = {13'd0, ie, auto_rl, en};
                A_LOAD:   rdata = load;
                A_COUNT:  rdata = count;
`ifdef TIMER_PRESCALER_EN
                A_PRESC:  rdata = prescale;
`endif
                A_STATUS: rdata = {15'd0, pend};
                default:  rdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: reset, auto-reload, one-shot, prescaler, set/clear collision, decode.
module tb_timer_irq;

    localparam logic [15:0] BASE = 16'h00F8;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, oe;
    logic [15:0] addresses, wdata;
    logic [15:0] rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    timer_irq #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .we(we), .oe(oe),
        .addresses(addresses), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] off, input logic [15:0] exp);
        oe = 1'b1;
        addresses = {BASE[15:3], off};
        #1;
        chk(tag, rdata, exp);
        oe = 1'b0;
    endtask

    // One bus write consumes exactly one rising edge; returns 1ns after it.
    task automatic wr_addr(input logic [15:0] a, input logic [15:0] d);
        we = 1'b1;
        addresses = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] d);
        wr_addr({BASE[15:3], off}, d);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; oe = 1'b0; addresses = '0; wdata = '0;

        // Reset held with bus activity
        we = 1'b1; addresses = BASE; wdata = 16'h0007;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        addresses = {BASE[15:3], 3'd1}; wdata = 16'h0005;
        @(posedge clk); #1;
        we = 1'b0;
        chk_reg("rst_rd_load", 3'd1, 16'h0000);
        @(negedge clk) reset = 1'b1;
        step(1);
        for (int i = 0; i < 8; i++)
            chk_reg($sformatf("post_rst_reg%0d", i), i[2:0], 16'h0000);
        chk("post_rst_irq", {15'd0, irq}, 16'h0000);

        // Auto-reload: LOAD=3, PRESCALE=0, CTRL=111 at E0
        wr(3'd1, 16'd3);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'h0007);                // E0
        chk_reg("ar_cnt_e0", 3'd2, 16'd3);
        step(1); chk_reg("ar_cnt_e1", 3'd2, 16'd2);
        step(1); chk_reg("ar_cnt_e2", 3'd2, 16'd1);
        step(1); chk_reg("ar_cnt_e3", 3'd2, 16'd0);
        chk("ar_irq_e3", {15'd0, irq}, 16'h0000);
        step(1);                           // E4
        chk_reg("ar_cnt_e4", 3'd2, 16'd3);
        chk_reg("ar_pend_e4", 3'd4, 16'd1);
        chk("ar_irq_e4", {15'd0, irq}, 16'h0001);
        wr(3'd4, 16'h0001);                // E5 clear
        chk("ar_irq_clr", {15'd0, irq}, 16'h0000);
        step(2);                           // E7
        chk("ar_irq_e7", {15'd0, irq}, 16'h0000);
        step(1);                           // E8
        chk("ar_irq_e8", {15'd0, irq}, 16'h0001);

        // Clear/set collision
        wr(3'd4, 16'h0001);                // E9 clear
        chk_reg("col_pend_e9", 3'd4, 16'd0);
        step(2);                           // E11
        wr(3'd4, 16'h0001);                // E12: expiry coincides with clear
        chk_reg("col_pend_e12", 3'd4, 16'd1);
        chk("col_irq_e12", {15'd0, irq}, 16'h0001);
        wr(3'd4, 16'h0001);                // E13
        chk_reg("col_pend_e13", 3'd4, 16'd0);
        chk("col_irq_e13", {15'd0, irq}, 16'h0000);
        wr(3'd4, 16'h0000);                // writing 0 leaves PEND alone
        wr(3'd0, 16'h0000);
        wr(3'd4, 16'h0001);

        // One-shot: LOAD=2, CTRL=101
        wr(3'd1, 16'd2);
        wr(3'd0, 16'h0005);                // E0
        step(2);                           // E2
        chk_reg("os_cnt_e2", 3'd2, 16'd0);
        chk_reg("os_pend_e2", 3'd4, 16'd0);
        step(1);                           // E3
        chk_reg("os_pend_e3", 3'd4, 16'd1);
        chk_reg("os_ctrl_e3", 3'd0, 16'h0004);
        chk_reg("os_cnt_e3", 3'd2, 16'd0);
        chk("os_irq_e3", {15'd0, irq}, 16'h0001);
        wr(3'd0, 16'h0000);                // IE off, PEND kept
        chk("os_irq_ie0", {15'd0, irq}, 16'h0000);
        chk_reg("os_pend_ie0", 3'd4, 16'd1);
        wr(3'd0, 16'h0004);                // IE back on
        chk("os_irq_ie1", {15'd0, irq}, 16'h0001);
        wr(3'd4, 16'h0001);
        step(10);
        chk_reg("os_pend_after", 3'd4, 16'd0);
        chk_reg("os_cnt_after", 3'd2, 16'd0);

        // Prescaler: PRESCALE=4, LOAD=1, CTRL=111
        wr(3'd3, 16'd4);
        wr(3'd1, 16'd1);
        wr(3'd0, 16'h0007);                // E0
`ifdef TIMER_PRESCALER_EN
        chk_reg("ps_presc_rd", 3'd3, 16'd4);
        step(4);
        chk_reg("ps_cnt_e4", 3'd2, 16'd1);
        step(1);
        chk_reg("ps_cnt_e5", 3'd2, 16'd0);
        step(4);
        chk("ps_irq_e9", {15'd0, irq}, 16'h0000);
        step(1);
        chk("ps_irq_e10", {15'd0, irq}, 16'h0001);
`else
        chk_reg("ps_presc_rd", 3'd3, 16'd0);
        step(1);
        chk_reg("ps_cnt_e1", 3'd2, 16'd0);
        chk("ps_irq_e1", {15'd0, irq}, 16'h0000);
        step(1);
        chk("ps_irq_e2", {15'd0, irq}, 16'h0001);
`endif
        wr(3'd0, 16'h0000);
        wr(3'd4, 16'h0001);

        // Address decode
        wr(3'd1, 16'h1234);
        wr_addr(16'h00FD, 16'hFFFF);
        wr_addr(16'h00F0, 16'hFFFF);
        wr_addr(16'h00F1, 16'hFFFF);
        chk_reg("dec_ctrl", 3'd0, 16'h0000);
        chk_reg("dec_load", 3'd1, 16'h1234);
        chk_reg("dec_count", 3'd2, 16'h1234);
        chk_reg("dec_status", 3'd4, 16'h0000);
        chk_reg("dec_off5", 3'd5, 16'h0000);
        oe = 1'b1; addresses = 16'h00F1; #1;
        chk("dec_rd_outside", rdata, 16'h0000);
        oe = 1'b0; addresses = {BASE[15:3], 3'd1}; #1;
        chk("dec_rd_oe0", rdata, 16'h0000);

        // Reset mid-countdown
        wr(3'd1, 16'd5);
        wr(3'd0, 16'h0007);
        step(2);
        #2 reset = 1'b0;
        #1;
        chk("midrst_irq", {15'd0, irq}, 16'h0000);
        @(negedge clk) reset = 1'b1;
        step(10);
        chk_reg("midrst_ctrl", 3'd0, 16'h0000);
        chk_reg("midrst_count", 3'd2, 16'h0000);
        chk_reg("midrst_pend", 3'd4, 16'h0000);
        chk("midrst_irq_after", {15'd0, irq}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
